// File: rtl/nibble_alu_pkg.sv
// Shared constants for the nibble ALU execute stage: opcodes, FSM encoding,
// flag bit positions and the flag-packing helper.
package nibble_alu_pkg;

    localparam int DATA_W      = 8;
    localparam int ITER_CYCLES = DATA_W;
    localparam int CNT_W       = $clog2(ITER_CYCLES);

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_ADC   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_SBB   = 4'h5;
    localparam logic [3:0] OP_NEG   = 4'h6;
    localparam logic [3:0] OP_INC   = 4'h7;
    localparam logic [3:0] OP_DEC   = 4'h8;
    localparam logic [3:0] OP_MUL   = 4'h9;
    localparam logic [3:0] OP_DIV   = 4'hA;
    localparam logic [3:0] OP_AND   = 4'hB;
    localparam logic [3:0] OP_OR    = 4'hC;
    localparam logic [3:0] OP_XOR   = 4'hD;
    localparam logic [3:0] OP_MOD   = 4'hE;
    localparam logic [3:0] OP_JUMP  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_ITER   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_N] = res[DATA_W-1];
        f[FLAG_V] = v;
        return f;
    endfunction

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/nibble_alu_execute_muldiv.sv
// Shared one-bit-per-cycle engine: right-shifting shift-add multiply and
// restoring division, both living in one double-width work register.
module nibble_muldiv_iter #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode_div,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   product,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             div_by_zero
);

    // MUL: hi = partial sum, lo = multiplier bits still to consume.
    // DIV: hi = running remainder, lo = dividend shifting out / quotient in.
    logic [2*W-1:0] work_q;
    logic [2*W-1:0] work_nxt;
    logic [W-1:0]   opnd_q;
    logic           mode_q;
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;

    always_comb begin
        mul_sum   = {1'b0, work_q[2*W-1:W]} + ({1'b0, opnd_q} & {(W+1){work_q[0]}});
        div_shift = {work_q[2*W-1:W], work_q[W-1]};
        if (!mode_q) begin
            work_nxt = {mul_sum, work_q[W-1:1]};
        end else if (div_shift >= {1'b0, opnd_q}) begin
            work_nxt = {W'(div_shift - {1'b0, opnd_q}), work_q[W-2:0], 1'b1};
        end else begin
            work_nxt = {div_shift[W-1:0], work_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_q <= '0;
            opnd_q <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            work_q <= {{W{1'b0}}, (mode_div ? a : b)};
            opnd_q <= mode_div ? b : a;
            mode_q <= mode_div;
        end else if (step) begin
            work_q <= work_nxt;
        end
    end

    // Outputs show the post-step value so the final step can be committed
    // by the caller on the same edge that performs it.
    assign product     = work_nxt;
    assign quotient    = work_nxt[W-1:0];
    assign remainder   = work_nxt[2*W-1:W];
    assign div_by_zero = (opnd_q == '0);

endmodule

// File: rtl/nibble_alu_execute.sv
// Execute stage behind the 4-bit decoder: single-cycle ALU ops plus an
// 8-cycle MUL/DIV/MOD engine, with a start/busy/done handshake.
module nibble_alu_execute
    import nibble_alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] mem_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              pc_load
);

    localparam int MSB = DATA_W - 1;

    state_t            state_q, state_nxt;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              cin_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              iter_last;

    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   quotient, remainder;
    logic                div_by_zero;

    logic              use_c;
    logic [DATA_W:0]   sum_ext, dif_ext;
    logic              add_v, sub_v;
    logic [DATA_W-1:0] neg_r, inc_r, dec_r;
    logic [DATA_W-1:0] alu_res, it_res;
    logic [3:0]        alu_flags, it_flags;

    assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign iter_last = (cnt_q == CNT_W'(ITER_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = is_iter_op(opcode) ? ST_ITER : ST_SINGLE;
                else       state_nxt = ST_IDLE;
            end
            ST_SINGLE: state_nxt = ST_DONE;
            ST_ITER:   if (iter_last) state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_SINGLE) || (state_q == ST_ITER);
        done = (state_q == ST_DONE);
    end

    nibble_muldiv_iter #(.W(DATA_W)) u_muldiv (
        .clk         (clk),
        .reset_n     (reset_n),
        .mode_div    (opcode != OP_MUL),
        .load        (accept),
        .step        (state_q == ST_ITER),
        .a           (acc_in),
        .b           (mem_in),
        .product     (product),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Single-cycle ALU; carry-in comes from the flag word captured at accept.
    always_comb begin
        use_c   = ((op_q == OP_ADC) || (op_q == OP_SBB)) && cin_q;
        sum_ext = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, use_c};
        dif_ext = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, use_c};
        add_v   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
        sub_v   = (a_q[MSB] != b_q[MSB]) && (dif_ext[MSB] != a_q[MSB]);
        neg_r   = '0 - a_q;
        inc_r   = a_q + DATA_W'(1);
        dec_r   = a_q - DATA_W'(1);

        alu_res   = a_q;
        alu_flags = flags;
        case (op_q)
            OP_LOAD: begin
                alu_res   = b_q;
                alu_flags = pack_flags(b_q, 1'b0, 1'b0);
            end
            OP_STORE: alu_res = a_q;
            OP_ADD, OP_ADC: begin
                alu_res   = sum_ext[MSB:0];
                alu_flags = pack_flags(sum_ext[MSB:0], sum_ext[DATA_W], add_v);
            end
            OP_SUB, OP_SBB: begin
                alu_res   = dif_ext[MSB:0];
                alu_flags = pack_flags(dif_ext[MSB:0], dif_ext[DATA_W], sub_v);
            end
            OP_NEG: begin
                alu_res   = neg_r;
                alu_flags = pack_flags(neg_r, a_q != '0, a_q == {1'b1, {MSB{1'b0}}});
            end
            OP_INC: begin
                alu_res   = inc_r;
                alu_flags = pack_flags(inc_r, a_q == '1, a_q == {1'b0, {MSB{1'b1}}});
            end
            OP_DEC: begin
                alu_res   = dec_r;
                alu_flags = pack_flags(dec_r, a_q == '0, a_q == {1'b1, {MSB{1'b0}}});
            end
            OP_AND: begin
                alu_res   = a_q & b_q;
                alu_flags = pack_flags(a_q & b_q, 1'b0, 1'b0);
            end
            OP_OR: begin
                alu_res   = a_q | b_q;
                alu_flags = pack_flags(a_q | b_q, 1'b0, 1'b0);
            end
            OP_XOR: begin
                alu_res   = a_q ^ b_q;
                alu_flags = pack_flags(a_q ^ b_q, 1'b0, 1'b0);
            end
            OP_JUMP: alu_res = b_q;
            default: ;
        endcase
    end

    // Final-step view of the iterative engine.
    always_comb begin
        it_res   = remainder;
        it_flags = pack_flags(remainder, 1'b0, 1'b0);
        case (op_q)
            OP_MUL: begin
                it_res   = product[MSB:0];
                it_flags = pack_flags(product[MSB:0], product[2*DATA_W-1:DATA_W] != '0, 1'b0);
            end
            OP_DIV: begin
                if (div_by_zero) begin
                    it_res   = '1;
                    it_flags = pack_flags('1, 1'b0, 1'b1);
                end else begin
                    it_res   = quotient;
                    it_flags = pack_flags(quotient, 1'b0, 1'b0);
                end
            end
            default: begin
                if (div_by_zero) begin
                    it_res   = a_q;
                    it_flags = pack_flags(a_q, 1'b0, 1'b1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            flags   <= '0;
            pc_load <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            if (accept) begin
                op_q  <= opcode;
                a_q   <= acc_in;
                b_q   <= mem_in;
                cin_q <= flags[FLAG_C];
                cnt_q <= '0;
            end
            if (state_q == ST_SINGLE) begin
                result  <= alu_res;
                flags   <= alu_flags;
                pc_load <= (op_q == OP_JUMP);
            end
            if (state_q == ST_ITER) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (iter_last) begin
                    result <= it_res;
                    flags  <= it_flags;
                end
            end
        end
    end

endmodule
